redirect_ctrl: RTL and testbench

- Sequences PC redirection for the RV32 pipeline; sits between the EX-stage branch resolution logic and the PC mux / pipeline registers.
- Takes the resolved branch, jal or jalr outcome and its target from EX, and drives pc_sel, pc_target and the flushes.
- Holds a redirect across stalls, then masks the shadow cycles after each redirect.
- Flags misaligned targets and out-of-range targets instead of redirecting.

---
 rtl/redirect_pkg.sv | 18 +
 rtl/redirect_target_chk.sv | 25 ++
 rtl/redirect_ctrl.sv | 160 ++++++++++++++++
 tb/tb_redirect_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/redirect_pkg.sv
// Shared types and constants for the PC redirect controller.
package redirect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SHADOW  = 2'd2
  } redir_state_t;

  typedef enum logic [1:0] {
    K_BR   = 2'd0,
    K_JAL  = 2'd1,
    K_JALR = 2'd2
  } redir_kind_t;

  localparam int SHADOW_CNT_W = 3;

endpackage

// File: rtl/redirect_target_chk.sv
// Target selection and legality check for an EX-stage control transfer.
// jalr takes rs1+imm with bit 0 cleared; branch and jal take PC+imm.
module redirect_target_chk #(
  parameter int PC_W = 9
) (
  input  logic            ex_jalr,
  input  logic [31:0]     ex_pc_imm,
  input  logic [31:0]     ex_alu_res,
  output logic [PC_W-1:0] target,
  output logic            aligned,
  output logic            in_range
);
  import redirect_pkg::*;

  logic [31:0] raw;

  // Pick the raw target and derive the truncated target and its legality flags.
  always_comb begin
    raw      = ex_jalr ? (ex_alu_res & ~32'd1) : ex_pc_imm;
    target   = raw[PC_W-1:0];
    aligned  = ~raw[1];
    in_range = (raw[31:PC_W] == '0);
  end

endmodule

// File: rtl/redirect_ctrl.sv
// PC redirect sequencer between EX branch resolution and the PC mux.
// Optional feature: define REDIRECT_STATS_EN to add saturating 16-bit
// redirect counters (stat_br, stat_jal, stat_jalr).
// Handshake: there is no valid/ready pair; stall=1 means the PC and IF/ID
// are frozen this cycle, so a redirect found under stall is parked in PENDING
// and issued on the first cycle stall is low.
module redirect_ctrl #(
  parameter int PC_W       = 9,
  parameter int SHADOW_CYC = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_taken,
  input  logic            ex_jal,
  input  logic            ex_jalr,
  input  logic [31:0]     ex_pc_imm,
  input  logic [31:0]     ex_alu_res,
  input  logic            stall,
  output logic            pc_sel,
  output logic [PC_W-1:0] pc_target,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            shadow,
  output logic            misalign_exc,
  output logic            range_exc,
`ifdef REDIRECT_STATS_EN
  output logic [15:0]     stat_br,
  output logic [15:0]     stat_jal,
  output logic [15:0]     stat_jalr,
`endif
  output logic [1:0]      dbg_state
);
  import redirect_pkg::*;

  localparam logic [SHADOW_CNT_W-1:0] SHADOW_INIT = SHADOW_CNT_W'(SHADOW_CYC - 1);

  redir_state_t            state_q, state_d;
  logic [PC_W-1:0]         tgt_q, tgt_d;
  logic [SHADOW_CNT_W-1:0] cnt_q, cnt_d;

  logic            req;
  logic [PC_W-1:0] chk_target;
  logic            chk_aligned;
  logic            chk_in_range;

  assign req       = ex_valid & ((ex_branch & ex_taken) | ex_jal | ex_jalr);
  assign dbg_state = state_q;

  redirect_target_chk #(.PC_W(PC_W)) u_chk (
    .ex_jalr   (ex_jalr),
    .ex_pc_imm (ex_pc_imm),
    .ex_alu_res(ex_alu_res),
    .target    (chk_target),
    .aligned   (chk_aligned),
    .in_range  (chk_in_range)
  );

  // State, parked target and shadow counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; exceptions are only raised from IDLE.
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    cnt_d        = cnt_q;
    pc_sel       = 1'b0;
    pc_target    = '0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    shadow       = 1'b0;
    misalign_exc = 1'b0;
    range_exc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!chk_aligned || !chk_in_range) begin
            misalign_exc = ~chk_aligned;
            range_exc    = ~chk_in_range;
          end else if (stall) begin
            flush_id_ex = 1'b1;
            tgt_d       = chk_target;
            state_d     = PENDING;
          end else begin
            pc_sel      = 1'b1;
            pc_target   = chk_target;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            cnt_d       = SHADOW_INIT;
            state_d     = SHADOW;
          end
        end
      end
      PENDING: begin
        pc_target = tgt_q;
        if (!stall) begin
          pc_sel      = 1'b1;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          cnt_d       = SHADOW_INIT;
          state_d     = SHADOW;
        end
      end
      SHADOW: begin
        shadow = 1'b1;
        if (!stall) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - SHADOW_CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef REDIRECT_STATS_EN
  redir_kind_t kind_now, kind_q, kind_cls;
  logic [15:0] stat_br_q, stat_jal_q, stat_jalr_q;

  // Classify the EX instruction; jalr wins over jal, jal over branch.
  always_comb begin
    if (ex_jalr)     kind_now = K_JALR;
    else if (ex_jal) kind_now = K_JAL;
    else             kind_now = K_BR;
    kind_cls = (state_q == PENDING) ? kind_q : kind_now;
  end

  // Remember the instruction kind of a parked redirect and count issued redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_q      <= K_BR;
      stat_br_q   <= '0;
      stat_jal_q  <= '0;
      stat_jalr_q <= '0;
    end else begin
      if (state_q == IDLE && state_d == PENDING) kind_q <= kind_now;
      if (pc_sel) begin
        if (kind_cls == K_BR && stat_br_q != 16'hFFFF)     stat_br_q   <= stat_br_q + 16'd1;
        if (kind_cls == K_JAL && stat_jal_q != 16'hFFFF)   stat_jal_q  <= stat_jal_q + 16'd1;
        if (kind_cls == K_JALR && stat_jalr_q != 16'hFFFF) stat_jalr_q <= stat_jalr_q + 16'd1;
      end
    end
  end

  assign stat_br   = stat_br_q;
  assign stat_jal  = stat_jal_q;
  assign stat_jalr = stat_jalr_q;
`endif

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl (PC_W=9, SHADOW_CYC=2).
module tb_redirect_ctrl;
  localparam int PC_W = 9;
  localparam logic [1:0] S_IDLE = 2'd0, S_PEND = 2'd1, S_SHAD = 2'd2;
  localparam logic [14:0] ZERO = 15'd0;

  logic            clk;
  logic            reset;
  logic            ex_valid, ex_branch, ex_taken, ex_jal, ex_jalr, stall;
  logic [31:0]     ex_pc_imm, ex_alu_res;
  logic            pc_sel, flush_if_id, flush_id_ex, shadow, misalign_exc, range_exc;
  logic [PC_W-1:0] pc_target;
  logic [1:0]      dbg_state;
`ifdef REDIRECT_STATS_EN
  logic [15:0]     stat_br, stat_jal, stat_jalr;
`endif

  int checks   = 0;
  int failures = 0;

  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] got_q[$];
  logic [14:0]     obs;

  redirect_ctrl #(.PC_W(PC_W), .SHADOW_CYC(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_branch   (ex_branch),
    .ex_taken    (ex_taken),
    .ex_jal      (ex_jal),
    .ex_jalr     (ex_jalr),
    .ex_pc_imm   (ex_pc_imm),
    .ex_alu_res  (ex_alu_res),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .pc_target   (pc_target),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .shadow      (shadow),
    .misalign_exc(misalign_exc),
    .range_exc   (range_exc),
`ifdef REDIRECT_STATS_EN
    .stat_br     (stat_br),
    .stat_jal    (stat_jal),
    .stat_jalr   (stat_jalr),
`endif
    .dbg_state   (dbg_state)
  );

  assign obs = {pc_sel, pc_target, flush_if_id, flush_id_ex, shadow, misalign_exc, range_exc};

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ov(input logic ps, input logic [8:0] t, input logic fi,
                                      input logic fe, input logic sh, input logic mi,
                                      input logic ra);
    return {ps, t, fi, fe, sh, mi, ra};
  endfunction

  // Driver: apply one cycle of EX inputs on the falling edge.
  task automatic drive(input logic v, input logic b, input logic tk, input logic j,
                       input logic jr, input logic [31:0] pi, input logic [31:0] alu,
                       input logic st);
    @(negedge clk);
    ex_valid = v; ex_branch = b; ex_taken = tk; ex_jal = j; ex_jalr = jr;
    ex_pc_imm = pi; ex_alu_res = alu; stall = st;
    #1;
  endtask

  task automatic cyc(input string tag, input logic v, input logic b, input logic tk,
                     input logic j, input logic jr, input logic [31:0] pi,
                     input logic [31:0] alu, input logic st, input logic [14:0] exp_o,
                     input logic [1:0] exp_st);
    drive(v, b, tk, j, jr, pi, alu, st);
    check({tag, "_out"}, 32'(obs), 32'(exp_o));
    check({tag, "_st"}, 32'(dbg_state), 32'(exp_st));
  endtask

  // Monitor: collect every issued redirect target for the scoreboard.
  always @(negedge clk) begin
    #2;
    if (reset && pc_sel) got_q.push_back(pc_target);
  end

  initial begin
    reset = 1'b0;
    ex_valid = 0; ex_branch = 0; ex_taken = 0; ex_jal = 0; ex_jalr = 0;
    ex_pc_imm = '0; ex_alu_res = '0; stall = 0;
    #1;
    check("reset_out", 32'(obs), 32'(ZERO));
    check("reset_st", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Taken beq to 0x40 without stall, then a jal inside the shadow is ignored.
    exp_q.push_back(9'h040);
    cyc("beq",   1,1,1,0,0, 32'h40, 0, 0, ov(1,9'h040,1,1,0,0,0), S_IDLE);
    cyc("shd1",  1,0,0,1,0, 32'h80, 0, 0, ov(0,0,0,0,1,0,0), S_SHAD);
    cyc("shd2",  1,0,0,1,0, 32'h80, 0, 0, ov(0,0,0,0,1,0,0), S_SHAD);
    cyc("post1", 0,0,0,0,0, 0, 0, 0, ZERO, S_IDLE);

    // jalr with rs1+imm = 0x85: bit 0 cleared, target 0x084.
    exp_q.push_back(9'h084);
    cyc("jalr",  1,0,0,0,1, 32'h0, 32'h85, 0, ov(1,9'h084,1,1,0,0,0), S_IDLE);
    cyc("jshd1", 0,0,0,0,0, 0, 0, 0, ov(0,0,0,0,1,0,0), S_SHAD);
    cyc("jshd2", 0,0,0,0,0, 0, 0, 0, ov(0,0,0,0,1,0,0), S_SHAD);
    cyc("post2", 0,0,0,0,0, 0, 0, 0, ZERO, S_IDLE);
`ifdef REDIRECT_STATS_EN
    check("stat_jalr1", 32'(stat_jalr), 32'd1);
`endif

    // jal to 0x20 under a 3-cycle stall; EX changes while PENDING are ignored.
    exp_q.push_back(9'h020);
    cyc("jal_st",  1,0,0,1,0, 32'h20, 0, 1, ov(0,0,0,1,0,0,0), S_IDLE);
    cyc("pend1",   1,1,1,0,0, 32'h12, 0, 1, ov(0,9'h020,0,0,0,0,0), S_PEND);
    cyc("pend2",   1,1,1,0,0, 32'h12, 0, 1, ov(0,9'h020,0,0,0,0,0), S_PEND);
    cyc("pend_go", 0,0,0,0,0, 0, 0, 0, ov(1,9'h020,1,1,0,0,0), S_PEND);
    // Shadow counter holds while stalled, so the window stretches to 3 cycles.
    cyc("pshd1",   0,0,0,0,0, 0, 0, 0, ov(0,0,0,0,1,0,0), S_SHAD);
    cyc("pshd2",   0,0,0,0,0, 0, 0, 1, ov(0,0,0,0,1,0,0), S_SHAD);
    cyc("pshd3",   0,0,0,0,0, 0, 0, 0, ov(0,0,0,0,1,0,0), S_SHAD);
    cyc("post3",   0,0,0,0,0, 0, 0, 0, ZERO, S_IDLE);

    // Illegal targets: misaligned, out of range, both, and misaligned under stall.
    cyc("mis",     1,1,1,0,0, 32'h12,  0, 0, ov(0,0,0,0,0,1,0), S_IDLE);
    cyc("mis_nx",  0,0,0,0,0, 0, 0, 0, ZERO, S_IDLE);
    cyc("rng",     1,1,1,0,0, 32'h400, 0, 0, ov(0,0,0,0,0,0,1), S_IDLE);
    cyc("both",    1,0,0,1,0, 32'h402, 0, 0, ov(0,0,0,0,0,1,1), S_IDLE);
    cyc("mis_st",  1,1,1,0,0, 32'h1FE, 0, 1, ov(0,0,0,0,0,1,0), S_IDLE);
    cyc("mis_snx", 0,0,0,0,0, 0, 0, 0, ZERO, S_IDLE);

    // No action: not-taken branch, and a jal in a bubble.
    cyc("ntaken",  1,1,0,0,0, 32'h40, 0, 0, ZERO, S_IDLE);
    cyc("bubble",  0,0,0,1,0, 32'h40, 0, 0, ZERO, S_IDLE);
`ifdef REDIRECT_STATS_EN
    check("stat_br", 32'(stat_br), 32'd1);
    check("stat_jal", 32'(stat_jal), 32'd1);
    check("stat_jalr", 32'(stat_jalr), 32'd1);
`endif

    // Asynchronous reset in the middle of a PENDING cycle.
    cyc("rjal",    1,0,0,1,0, 32'h60, 0, 1, ov(0,0,0,1,0,0,0), S_IDLE);
    cyc("rpend",   0,0,0,0,0, 0, 0, 1, ov(0,9'h060,0,0,0,0,0), S_PEND);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_out", 32'(obs), 32'(ZERO));
    check("rst_mid_st", 32'(dbg_state), 32'(S_IDLE));
`ifdef REDIRECT_STATS_EN
    check("rst_stat_br", 32'(stat_br), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    cyc("after_rst", 0,0,0,0,0, 0, 0, 0, ZERO, S_IDLE);
    cyc("after_rs2", 0,0,0,0,0, 0, 0, 0, ZERO, S_IDLE);

    // Scoreboard: redirect targets in issue order.
    check("rd_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("rd_tgt%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
